fpu_issue_ctrl: RTL

//  Issue/completion controller for the multicycle FPU datapath. Accepts one FP op at a time

---
 rtl/fpu_issue_ctrl_if.sv | 31 +++
 rtl/fpu_issue_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// Request/response handshake bundle between the EX stage (master) and the FPU issue controller (slave).
// Request: valid/ready plus op fields and operands. Response: valid/ready plus result and destination tag.
// Backpressure: the request is held until req_ready; the response is held until resp_ready.
interface fpu_issue_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [2:0]       req_func3;
  logic             req_rs2_0;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] req_c;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_func3, req_rs2_0, req_a, req_b, req_c, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_func3, req_rs2_0, req_a, req_b, req_c, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Single-op issue/completion controller for the multicycle FPU; FPU_FLAGS_EN adds exception flags.
// Latency: accept cycle to first resp_valid cycle = LAT(op)+2; one op in flight (LAT+3 per op back-to-back).
// Backpressure: req_ready only in IDLE; the result is held in DONE until resp_ready; flush drops the op.
module fpu_issue_ctrl #(
  parameter int WIDTH    = 32,
  parameter int TAG_W    = 5,
  parameter int CNT_W    = 5,
  parameter int LAT_ADD  = 7,
  parameter int LAT_MUL  = 5,
  parameter int LAT_DIV  = 6,
  parameter int LAT_CMP  = 1,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CVT  = 6
) (
  input  logic             clock,
  input  logic             clear_n,
  fpu_issue_ctrl_if.slave  bus,
  input  logic             flush,
  output logic             fpu_sel,
  output logic [3:0]       fpu_op,
  output logic [2:0]       fpu_func3,
  output logic             fpu_rs2_0,
  output logic [WIDTH-1:0] fpu_a,
  output logic [WIDTH-1:0] fpu_b,
  output logic [WIDTH-1:0] fpu_c,
  input  logic [WIDTH-1:0] fpu_result,
`ifdef FPU_FLAGS_EN
  input  logic [4:0]       fpu_flags,
  input  logic             fflags_clr,
  output logic [4:0]       resp_flags,
  output logic [4:0]       fflags,
`endif
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] resp_data_q;
  logic [TAG_W-1:0] resp_tag_q;

  // Fused ops run multiply then add; the sum deliberately wraps at CNT_W bits.
  function automatic logic [CNT_W-1:0] lat_of(input logic [3:0] op);
    case (op)
      4'd0, 4'd1:                 lat_of = CNT_W'(LAT_ADD);
      4'd2:                       lat_of = CNT_W'(LAT_MUL);
      4'd3:                       lat_of = CNT_W'(LAT_DIV);
      4'd5, 4'd7:                 lat_of = CNT_W'(LAT_CMP);
      4'd6:                       lat_of = CNT_W'(LAT_SQRT);
      4'd8, 4'd9:                 lat_of = CNT_W'(LAT_CVT);
      4'd10, 4'd11, 4'd12, 4'd13: lat_of = CNT_W'(LAT_MUL) + CNT_W'(LAT_ADD);
      default:                    lat_of = '0;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tag_q       <= '0;
      fpu_op      <= '0;
      fpu_func3   <= '0;
      fpu_rs2_0   <= 1'b0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      fpu_c       <= '0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && !flush) begin
            fpu_op    <= bus.req_op;
            fpu_func3 <= bus.req_func3;
            fpu_rs2_0 <= bus.req_rs2_0;
            fpu_a     <= bus.req_a;
            fpu_b     <= bus.req_b;
            fpu_c     <= bus.req_c;
            tag_q     <= bus.req_tag;
            cnt       <= lat_of(bus.req_op);
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (flush) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            resp_data_q <= fpu_result;
            resp_tag_q  <= tag_q;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush || bus.resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FPU_FLAGS_EN
  // A flush in DONE drops the op, so its flags never reach the sticky register.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      resp_flags <= '0;
      fflags     <= '0;
    end else begin
      if (state == S_EXEC && !flush && cnt == '0) resp_flags <= fpu_flags;
      if (fflags_clr)
        fflags <= '0;
      else if (state == S_DONE && bus.resp_ready && !flush)
        fflags <= fflags | resp_flags;
    end
  end
`endif

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_DONE);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_tag   = resp_tag_q;
  assign fpu_sel        = (state == S_EXEC);
  assign busy           = (state != S_IDLE);

endmodule
